// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only master: FSM states, quarter-phase
// names within one SCL period, and the R/W bit value this block always sends.
package i2c_pkg;

  // Bus phases of one write transaction
  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    DATA,
    ACK_D,
    STOP
  } state_t;

  // Quarter phases of every START / bit / STOP slot
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // R/W bit appended to the 7-bit address; this master only writes
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator. Counts system clocks while enabled and pulses
// tick for one clock every DIV clocks; the count is held at zero when disabled
// so every transaction starts on a fresh quarter boundary.
module i2c_clk_div #(
  parameter int unsigned DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter, cleared whenever the master is idle
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master. A command starts a START, the address byte with the
// write bit, then streams bytes from the data/data_valid interface, each
// followed by an ACK slot, until the source runs dry or the target NACKs, and
// finishes with a STOP. SCL and SDA are driven open-drain through *_oe.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int unsigned DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  qtr;        // current quarter inside the slot
  logic [2:0]  bit_cnt;    // bits left in the byte after the current one
  logic [7:0]  shreg;      // byte on the wire, MSB is the current bit
  logic        ack_bit;    // SDA level captured in the ACK slot
  logic        sda_meta;
  logic        sda_sync;
  logic        tick;
  logic        q_end;
  logic        in_ack;
  logic        last_bit;

  assign busy     = (state != IDLE);
  assign q_end    = tick && (qtr == Q3);
  assign in_ack   = (state == ACK_A) || (state == ACK_D);
  assign last_bit = (bit_cnt == 3'd0);

  i2c_clk_div #(
    .DIV (DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous SDA input
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the synchronizer resets to 1, the level of a released open-drain
    // line, so a reset can never look like a target ACK.
    if (!rst_n) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; every slot lasts four quarters
  always_comb begin
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = START;
      START: if (q_end) state_nxt = ADDR;
      ADDR:  if (q_end && last_bit) state_nxt = ACK_A;
      DATA:  if (q_end && last_bit) state_nxt = ACK_D;
      ACK_A,
      ACK_D: begin
        if (q_end) begin
          if (!ack_bit && data_valid) state_nxt = DATA;
          else                        state_nxt = STOP;
        end
      end
      STOP:  if (q_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: quarter counter, bit counter, shift register, ACK capture,
  // error flag and the end-of-transaction pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qtr     <= Q0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      ack_bit <= 1'b0;
      ack_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        qtr <= Q0;
        if (cmd_valid) begin
          shreg   <= {addr, RW_WRITE};
          bit_cnt <= 3'd7;
          ack_err <= 1'b0;
        end
      end else if (tick) begin
        qtr <= qtr + 2'd1;  // wraps Q3 -> Q0 at each slot boundary
        if (in_ack && qtr == Q2) begin
          ack_bit <= sda_sync;
        end
        if (qtr == Q3) begin
          case (state)
            ADDR,
            DATA: begin
              bit_cnt <= bit_cnt - 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
            end
            ACK_A,
            ACK_D: begin
              if (ack_bit) begin
                ack_err <= 1'b1;
              end else if (data_valid) begin
                shreg   <= data;
                bit_cnt <= 3'd7;
              end
            end
            STOP:    done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Bus drive and byte handshake decoded from state and quarter.
  // SCL is pulled low in Q0-Q1 of every bit, so SDA only moves while SCL is low.
  always_comb begin
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    data_ready = 1'b0;
    case (state)
      START: begin
        sda_oe = qtr[1];
      end
      ADDR,
      DATA: begin
        scl_oe = ~qtr[1];
        sda_oe = ~shreg[7];
      end
      ACK_A,
      ACK_D: begin
        scl_oe     = ~qtr[1];
        data_ready = q_end && !ack_bit && data_valid;
      end
      STOP: begin
        scl_oe = (qtr == Q0);
        sda_oe = (qtr != Q3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx at DIV=4. A behavioural bus monitor decodes
// START/STOP, bytes and ACK bits from the open-drain lines and plays a target
// that ACKs every byte except an optionally chosen one. Expected bytes, ACKs,
// handshake counts and SCL timing come from the transaction description alone.
module tb_i2c_master_tx;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;
  logic       tgt_pull = 1'b0;

  assign sda_i = ~(sda_oe | tgt_pull);

  always #5 clk = ~clk;

  i2c_master_tx #(
    .DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .addr       (addr),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor / target model ----------------
  logic [7:0] rx_bytes[$];
  logic       rx_acks[$];
  int         lo_q[$];
  int         hi_q[$];
  int         n_start = 0, n_stop = 0, n_ready = 0, n_done = 0;
  int         bitcnt = 0, byte_no = 0, nack_idx = -1;
  int         cyc = 0, last_edge = 0;
  logic [7:0] sh = 8'h00;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       scl_l, sda_l;

  always @(negedge clk) begin
    cyc++;
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | tgt_pull);
    if (data_ready) n_ready++;
    if (done) n_done++;
    if (scl_l && prev_scl && sda_l != prev_sda) begin
      if (!sda_l) begin
        n_start++;
        bitcnt  = 0;
        byte_no = 0;
      end else begin
        n_stop++;
      end
    end
    if (scl_l && !prev_scl) begin
      lo_q.push_back(cyc - last_edge);
      last_edge = cyc;
      if (bitcnt < 8) sh = {sh[6:0], sda_l};
      bitcnt++;
      if (bitcnt == 8) rx_bytes.push_back(sh);
      if (bitcnt == 9) rx_acks.push_back(sda_l);
    end
    if (!scl_l && prev_scl) begin
      hi_q.push_back(cyc - last_edge);
      last_edge = cyc;
      if (bitcnt == 8) begin
        tgt_pull = (byte_no != nack_idx);
        byte_no++;
      end else if (bitcnt == 9) begin
        tgt_pull = 1'b0;
        bitcnt   = 0;
      end
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  // ---------------- byte source ----------------
  logic [7:0] tx_q[$];

  initial begin : feeder
    logic rd;
    forever begin
      @(negedge clk);
      rd = data_ready;
      @(posedge clk);
      #1;
      if (rd && tx_q.size() > 0) void'(tx_q.pop_front());
      data_valid = (tx_q.size() > 0);
      if (tx_q.size() > 0) data = tx_q[0];
      else                 data = 8'h00;
    end
  end

  // ---------------- transaction runner with reference model ----------------
  logic [7:0] pend[4];

  // nk: index on the bus (0 = address byte) that the target NACKs, -1 for none
  task automatic run_txn(input logic [6:0] a, input int n, input int nk,
                         input string tag, input bit poke_busy);
    logic [7:0] exp_bus[$];
    int   sent;
    bit   nacked;
    int   to;
    exp_bus = {};
    exp_bus.push_back({a, 1'b0});
    for (int i = 0; i < n; i++) exp_bus.push_back(pend[i]);
    nacked = (nk >= 0 && nk <= n);
    sent   = nacked ? nk + 1 : n + 1;

    rx_bytes = {};
    rx_acks  = {};
    lo_q     = {};
    hi_q     = {};
    n_start  = 0;
    n_stop   = 0;
    n_ready  = 0;
    n_done   = 0;
    nack_idx = nk;
    tx_q     = {};
    for (int i = 0; i < n; i++) tx_q.push_back(pend[i]);
    repeat (3) @(posedge clk);
    #1;
    addr      = a;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    addr      = 7'($urandom);
    check({tag, ":busy_rise"}, busy, 1);
    check({tag, ":ack_err_clr"}, ack_err, 0);
    if (poke_busy) begin
      repeat (40) @(posedge clk);
      #1;
      addr      = a ^ 7'h7f;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    to = 0;
    while (done !== 1'b1 && to < 5000) begin
      @(negedge clk);
      to++;
    end
    check({tag, ":done_seen"}, done, 1);
    check({tag, ":busy_at_done"}, busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check({tag, ":done_pulses"}, n_done, 1);
    check({tag, ":starts"}, n_start, 1);
    check({tag, ":stops"}, n_stop, 1);
    check({tag, ":data_ready_cnt"}, n_ready, sent - 1);
    check({tag, ":ack_err"}, ack_err, nacked);
    check({tag, ":left_in_src"}, tx_q.size(), n - (sent - 1));
    check({tag, ":bytes_cnt"}, rx_bytes.size(), sent);
    check({tag, ":acks_cnt"}, rx_acks.size(), sent);
    for (int i = 0; i < sent && i < rx_bytes.size(); i++)
      check($sformatf("%s:byte%0d", tag, i), rx_bytes[i], exp_bus[i]);
    for (int i = 0; i < sent && i < rx_acks.size(); i++)
      check($sformatf("%s:ack%0d", tag, i), rx_acks[i], (i == nk) ? 1 : 0);
    tx_q = {};
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int to;
    #1;
    check("rst:scl_oe", scl_oe, 0);
    check("rst:sda_oe", sda_oe, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:ack_err", ack_err, 0);
    check("rst:data_ready", data_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: single byte, all ACKs; also SCL timing (Test 6)
    pend[0] = 8'hA5;
    run_txn(7'h50, 1, -1, "t1", 1'b0);
    check("t6:low_cnt", lo_q.size(), 19);
    check("t6:high_cnt", hi_q.size(), 19);
    for (int i = 0; i < 18 && i < lo_q.size(); i++)
      check($sformatf("t6:low%0d", i), lo_q[i], 2 * DIV);
    if (lo_q.size() == 19) check("t6:stop_low", lo_q[18], DIV);
    for (int i = 1; i < 19 && i < hi_q.size(); i++)
      check($sformatf("t6:high%0d", i), hi_q[i], 2 * DIV);

    // Test 2: address NACK with a byte waiting
    pend[0] = 8'h77;
    run_txn(7'h3C, 1, 0, "t2", 1'b0);

    // Test 3: three back-to-back bytes
    pend[0] = 8'h01;
    pend[1] = 8'h02;
    pend[2] = 8'h03;
    run_txn(7'h21, 3, -1, "t3", 1'b0);

    // Test 4: cmd_valid while busy is ignored
    pend[0] = 8'h9C;
    run_txn(7'h12, 1, -1, "t4", 1'b1);

    // Zero-byte write and data-byte NACK
    run_txn(7'h6B, 0, -1, "zero", 1'b0);
    pend[0] = 8'hF0;
    pend[1] = 8'h0F;
    run_txn(7'h05, 2, 1, "dnack", 1'b0);

    // Test 5: reset during bit 3 of the data byte
    pend[0] = 8'hC3;
    rx_acks  = {};
    nack_idx = -1;
    tx_q     = {};
    tx_q.push_back(8'hC3);
    repeat (3) @(posedge clk);
    #1;
    addr      = 7'h44;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    to = 0;
    while (!(rx_acks.size() == 1 && bitcnt == 3 && scl_oe === 1'b1) && to < 5000) begin
      @(negedge clk);
      #1;
      to++;
    end
    check("t5:reach_bit3", bitcnt, 3);
    rst_n = 1'b0;
    #1;
    check("t5:scl_oe", scl_oe, 0);
    check("t5:sda_oe", sda_oe, 0);
    check("t5:busy", busy, 0);
    check("t5:done", done, 0);
    check("t5:data_ready", data_ready, 0);
    tx_q     = {};
    tgt_pull = 1'b0;
    bitcnt   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend[0] = 8'h3E;
    run_txn(7'h44, 1, -1, "t5_after", 1'b0);

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      int n, nk;
      n  = $urandom_range(0, 3);
      nk = $urandom_range(0, 5) - 1;
      for (int i = 0; i < 4; i++) pend[i] = 8'($urandom);
      run_txn(7'($urandom), n, nk, $sformatf("rnd%0d", t), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_tx.md
I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 The block SHALL have parameter DIV, default 25, meaning system clocks per quarter SCL period; legal range 2..65535 (default gives 100 kHz SCL at a 10 MHz clk).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state is in this domain.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1, a request to start a write transaction.
REQ-005 The block SHALL have port addr, input, 7, the 7-bit target address, sampled when cmd_valid is accepted.
REQ-006 The block SHALL have port data, input, 8, the next write byte.
REQ-007 The block SHALL have port data_valid, input, 1, meaning data holds a byte to send.
REQ-008 The block SHALL have port data_ready, output, 1, a one-cycle pulse when the byte on data is consumed.
REQ-009 The block SHALL have port busy, output, 1, high from accepted cmd_valid until STOP completes.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when the transaction ends.
REQ-011 The block SHALL have port ack_err, output, 1, set when the target NACKs; cleared on the next accepted command.
REQ-012 The block SHALL have port scl_oe, output, 1, where 1 pulls SCL low and 0 releases it (open-drain).
REQ-013 The block SHALL have port sda_oe, output, 1, where 1 pulls SDA low and 0 releases it (open-drain).
REQ-014 The block SHALL have port sda_i, input, 1, the SDA line level, asynchronous to clk.

Function
REQ-015 A quarter tick SHALL pulse once every DIV clocks while busy; the divider SHALL be held at zero while idle.
REQ-016 States SHALL be: IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP.
REQ-017 IDLE: scl_oe=0, sda_oe=0; cmd_valid SHALL be accepted only here; cmd_valid while busy SHALL be ignored.
REQ-018 START (4 quarters): Q0-Q1 both lines released; Q2-Q3 sda_oe=1 with SCL released; then enter ADDR.
REQ-019 Each bit (4 quarters): Q0-Q1 scl_oe=1 with SDA set at Q0 entry; Q2-Q3 SCL released; SDA SHALL NOT change while SCL is released.
REQ-020 ADDR SHALL send {addr, 1'b0} (R/W=0, write), MSB first; sda_oe is the inverse of the bit value.
REQ-021 ACK_A/ACK_D: SDA SHALL be released for the whole bit; the synchronized sda_i SHALL be sampled at the end of Q2.
REQ-022 On ACK (sample 0) with data_valid=1 at the end of Q3: load data, pulse data_ready for 1 cycle, enter DATA.
REQ-023 On ACK with data_valid=0: enter STOP (a zero-byte write after the address is legal).
REQ-024 On NACK (sample 1): set ack_err, do not pulse data_ready, enter STOP.
REQ-025 STOP (4 quarters): Q0 scl_oe=1, sda_oe=1; Q1-Q2 SCL released, sda_oe=1; Q3 both lines released; then done pulses for 1 cycle, busy falls in the same cycle, and the state returns to IDLE.
REQ-026 A command accepted in cycle N SHALL raise busy in cycle N+1.
REQ-027 There SHALL be no byte-count limit; clock stretching and arbitration are not supported.
REQ-028 sda_i SHALL pass through a 2-flop synchronizer before use.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force scl_oe=0, sda_oe=0, busy=0, done=0, data_ready=0, ack_err=0, state IDLE, divider and bit counter 0, and synchronizer flops 1, including mid-transaction.
REQ-030 After rst_n rises, the block SHALL be idle and accept cmd_valid on the next clock edge.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enumeration, quarter-phase constants (Q0..Q3) and the R/W bit constant.
REQ-032 A sub-module i2c_clk_div SHALL generate the quarter tick from DIV, with an enable input tied to busy.

Verification (DIV=4, so SCL period = 16 clk)
REQ-033 Test 1: addr=0x50, one byte 0xA5, all ACKs -> SDA bits 1010000_0, ACK, 10100101, ACK, STOP; one data_ready; done=1 for 1 cycle; ack_err=0.
REQ-034 Test 2: addr=0x3C, sda_i held high (NACK on address) -> ack_err=1, no data_ready, STOP generated, done pulses.
REQ-035 Test 3: three bytes 0x01, 0x02, 0x03 presented back-to-back, then data_valid=0 -> exactly 3 data_ready pulses, 4 ACK slots, one STOP.
REQ-036 Test 4: cmd_valid pulsed while busy -> ignored; exactly one START is seen on the bus.
REQ-037 Test 5: rst_n=0 during DATA bit 3 -> scl_oe=sda_oe=0 in the same cycle; busy=0; a new command afterwards completes normally.
REQ-038 Test 6: measure timing -> SCL low 8 clk and high 8 clk; zero SDA edges while SCL is high except at START and STOP.
